// File: rtl/dil_word_packer.sv
// -----------------------------------------------------------------------------
// dil_word_packer
//
// Packs a byte stream holding one Dilithium test-vector field into W-bit words
// for a DUT data-in port. For a programmed field length N it emits
// ceil(N*8/W) words. It zero-pads the final partial word and flags that word
// with m_last. It sustains one byte per cycle under backpressure, with no
// bubble at word boundaries.
//
// Build option:
//   DIL_PACKER_BYTE_SWAP_EN - when defined, byte k of a word lands in the
//                             big-endian lane [W-1-8k : W-8-8k] and the
//                             padding of the last word occupies the low
//                             bytes. Handshakes and timing are unchanged.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        single-cycle pulse; begins a field, sampled only in IDLE
//   field_bytes  field length N in bytes, latched on an accepted start
//   busy         high from the cycle after start up to and including done
//   done         single-cycle pulse once the last word has been taken
//   s_data       input byte
//   s_valid      input byte valid
//   s_ready      packer accepts a byte this cycle
//   m_data       packed output word
//   m_valid      output word valid
//   m_ready      consumer accepts the word
//   m_last       marks the final word of the field (qualified by m_valid)
// -----------------------------------------------------------------------------
module dil_word_packer #(
  parameter int unsigned W        = 64,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BITS-1:0] field_bytes,
  output logic                busy,
  output logic                done,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [W-1:0]        m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int unsigned Lanes = W / 8;
  localparam int unsigned IdxW  = $clog2(Lanes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Lanes - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e              state_q;
  logic [LEN_BITS-1:0] bytes_left_q;
  logic [IdxW-1:0]     idx_q;
  logic [W-1:0]        acc_q;
  logic [W-1:0]        m_data_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic                busy_q;
  logic                done_q;

  logic [W-1:0]        word_next;
  logic                final_byte;
  logic                word_done;
  logic                out_free;
  logic                byte_fire;
  logic                out_fire;

  // A byte closes the current word when it fills the top lane or is the last
  // byte of the field.
  assign final_byte = (bytes_left_q == LEN_BITS'(1));
  assign word_done  = final_byte || (idx_q == LastIdx);

  // The output register may take a new word if it is empty or draining now.
  assign out_free   = !m_valid_q || m_ready;

  // Only a word-closing byte has to wait for the output register.
  assign s_ready    = (state_q == StFill) && (!word_done || out_free);
  assign byte_fire  = s_valid && s_ready;
  assign out_fire   = m_valid_q && m_ready;

  // Merge the incoming byte into its lane. The accumulator starts at zero for
  // each word, so the lanes a short final word never writes remain zero.
  always_comb begin
    word_next = acc_q;
    for (int unsigned k = 0; k < Lanes; k++) begin
      if (idx_q == IdxW'(k)) begin
`ifdef DIL_PACKER_BYTE_SWAP_EN
        word_next[W-8-8*k +: 8] = s_data;
`else
        word_next[8*k +: 8] = s_data;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bytes_left_q <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Output register: a reload wins over a handshake in the same cycle.
      if (byte_fire && word_done) begin
        m_data_q  <= word_next;
        m_valid_q <= 1'b1;
        m_last_q  <= final_byte;
      end else if (out_fire) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      done_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start) begin
            bytes_left_q <= field_bytes;
            idx_q        <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b1;
            if (field_bytes == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFill;
            end
          end
        end

        StFill: begin
          if (byte_fire) begin
            if (bytes_left_q != '0) begin
              bytes_left_q <= bytes_left_q - LEN_BITS'(1);
            end
            if (word_done) begin
              idx_q <= '0;
              acc_q <= '0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
              acc_q <= word_next;
            end
            if (final_byte) begin
              state_q <= StDrain;
            end
          end
        end

        StDrain: begin
          if (out_fire && m_last_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/dil_word_packer.md
# dil_word_packer

Packs a byte stream of one Dilithium test-vector field (seed, s1, s2, t0, t1, z, h, message) into W-bit words for the DUT input port. Sits between the testbench KAT byte loader and the DUT data-in interface. For each programmed field length it emits ceil(N·8/W) words, zero-pads the final partial word and flags it with `m_last`. Runs at one byte per cycle under backpressure.

## Interface
- `W`, 64, output word width in bits; 64 for high-performance DUT, 32 otherwise; multiple of 8, ≥ 16
- `LEN_BITS`, 16, width of the field byte-length input; covers the largest message, 3300 bytes
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle pulse; begins a field; sampled only in IDLE
- `field_bytes`  in  LEN_BITS  field length N in bytes; latched on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` until `done`, inclusive
- `done`  out  1  single-cycle pulse when the field is complete
- `s_data`  in  8  input byte
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  packer accepts a byte this cycle
- `m_data`  out  W  packed output word
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  DUT accepts the word
- `m_last`  out  1  qualifies the final word of the field; meaningful only with `m_valid`

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: accepting `start` latches `bytes_left = N` and clears the byte index. N = 0 → DONE; otherwise → FILL.
- FILL: a byte is transferred when `s_valid && s_ready`. Byte k of the current word goes to bits [8k+7:8k]. The first byte of the field is byte 0 of word 0.
- A word completes when the index reaches W/8−1 or `bytes_left` reaches 1. On completion:
  - unused upper bytes are zeroed;
  - the word loads the output register and `m_valid` is set;
  - `m_last` = 1 if it was the final byte;
  - the index resets to 0.
- After the final byte: FILL → DRAIN.
- `s_ready` = FILL && (the byte would not complete a word || !`m_valid` || `m_ready`). An output word is never overwritten while stalled.
- Output register: holds `m_data`/`m_last` stable while `m_valid && !m_ready`. It clears `m_valid` on handshake unless it reloads in the same cycle.
- DRAIN: the handshake of the word carrying `m_last` → DONE.
- DONE: `done` is high for one cycle, then → IDLE.
- `start` while not IDLE is ignored. `s_valid` outside FILL is ignored and `s_ready` stays 0.
- Output word count = ceil(N / (W/8)). `bytes_left` decrements by 1 per accepted byte and never underflows.

## Timing
- Reset values:
  - `s_ready`, `m_valid`, `m_last`, `busy` and `done` = 0;
  - `m_data` = 0;
  - state = IDLE; counters = 0.
- `start` at cycle 0 → FILL and `s_ready` = 1 at cycle 1.
- With continuous `s_valid`/`m_ready`: byte j is accepted at cycle 1+j, and word i has `m_valid` at cycle 1+(i+1)·W/8, one cycle after its completing byte.
- Sustained throughput is one byte per cycle with no bubbles at word boundaries.
- `done` fires one cycle after the final word handshake. A new `start` is accepted the cycle after `done`.
- For N = 0, `done` fires at cycle 1 and no word is emitted.
- Reset asserted mid-field aborts immediately: all outputs go to reset values and the partial word is discarded.

## Configuration
- `DIL_PACKER_BYTE_SWAP_EN`:
  - Defined: byte k of a word goes to bits [W−1−8k : W−8−8k] (big-endian word packing), and the padding in the final word occupies the low bytes.
  - Undefined (default): little-endian packing as described in Operation.
  - Handshakes, counts and timing are identical in both builds.

## Test plan
- W=64, N=32 (seed), bytes 0x00..0x1F streamed, `m_ready`=1:
  - exactly 4 words, first `m_data`=0x0706050403020100;
  - `m_last` only on word 3 (0x1F1E1D1C1B1A1918);
  - `done` one cycle after the last handshake.
- W=64, N=3300 (max message):
  - 413 words;
  - word 412 = {32'h0, bytes 3299..3296}, `m_last`=1.
- Backpressure: W=32, N=12, `m_ready` low for 5 cycles when the first word is valid:
  - `m_data` stays stable;
  - `s_ready` drops on the 4th byte of word 1 until the handshake;
  - no byte is lost; 3 words are emitted.
- N=0 → `done` at cycle 1, `m_valid` never asserted; `start` during `busy` with N=8 is ignored.
- Reset mid-field: assert `rst_n`=0 after 5 of 16 bytes → all outputs 0 immediately. A fresh `start` with N=8 then yields 1 correct word.
- With `DIL_PACKER_BYTE_SWAP_EN` defined, W=64, N=4, bytes 0xAA,0xBB,0xCC,0xDD → `m_data`=0xAABBCCDD00000000, `m_last`=1.
